// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : arb_pkg
// Brief   : Shared types and constants for the instruction/data memory arbiter.
// Revision: 1.0  initial release
// ============================================================================
package arb_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Owner of the transaction currently in flight
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // Full-word byte enable used by fetches and loads
    localparam logic [3:0] BE_ALL = 4'hF;

    // Counter widths: latency up to 8, starve limit up to 15
    localparam int LAT_W    = 4;
    localparam int STARVE_W = 4;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/arb_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module  : arb_starve_ctr
// Brief   : Saturating count of data grants taken while a fetch is waiting;
//           raises force_if once the fetch has been passed over too often.
// Revision: 1.0  initial release
// ============================================================================
module arb_starve_ctr
    import arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic d_grant,
    input  logic if_grant,
    input  logic if_pending,
    output logic force_if
);

    localparam logic [STARVE_W-1:0] c_LIMIT = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] r_cnt;

    // Count data grants that bypass a pending fetch; any fetch grant clears
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (if_grant) begin
            r_cnt <= '0;
        end else if (d_grant && if_pending && (r_cnt < c_LIMIT)) begin
            r_cnt <= r_cnt + STARVE_W'(1);
        end
    end

    assign force_if = (r_cnt == c_LIMIT);

endmodule : arb_starve_ctr
`default_nettype wire

// File: rtl/imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : imem_dmem_arbiter
// Brief   : Shares one single-port synchronous memory between the fetch and
//           load/store ports; one transaction at a time, data has priority,
//           a starvation guard guarantees fetch progress.
// Revision: 1.0  initial release
// ============================================================================
module imem_dmem_arbiter
    import arb_pkg::*;
#(
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    // Instruction fetch port
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    // Load/store port
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    // Memory port
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [LAT_W-1:0] c_MEM_LAT = LAT_W'(MEM_LAT);

    state_t             r_state;
    state_t             w_next_state;
    owner_t             r_owner;
    logic               r_we;
    logic [3:0]         r_be;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [LAT_W-1:0]   r_lat_cnt;
    logic [31:0]        r_if_rdata;
    logic [31:0]        r_d_rdata;

    logic               w_can_grant;
    logic               w_grant_if;
    logic               w_grant_d;
    logic               w_force_if;
    logic               w_capture;

    // RESP doubles as an idle cycle so back-to-back transactions need no bubble
    assign w_can_grant = reset && ((r_state == ST_IDLE) || (r_state == ST_RESP));
    assign w_grant_if  = w_can_grant && if_req && (!d_req || w_force_if);
    assign w_grant_d   = w_can_grant && d_req  && !(if_req && w_force_if);
    // Read data is valid on the last WAIT cycle
    assign w_capture   = (r_state == ST_WAIT) && (r_lat_cnt == LAT_W'(1));

    arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .reset      (reset),
        .d_grant    (w_grant_d),
        .if_grant   (w_grant_if),
        .if_pending (if_req),
        .force_if   (w_force_if)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and single-cycle strobes
    always_comb begin
        w_next_state = r_state;
        if_gnt       = 1'b0;
        d_gnt        = 1'b0;
        mem_en       = 1'b0;
        if_rvalid    = 1'b0;
        d_rvalid     = 1'b0;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                if (w_grant_if || w_grant_d) begin
                    w_next_state = ST_ISSUE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ISSUE: w_next_state = ST_WAIT;
            ST_WAIT: begin
                if (w_capture) begin
                    w_next_state = ST_RESP;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
        if (reset) begin
            if_gnt    = w_grant_if;
            d_gnt     = w_grant_d;
            mem_en    = (r_state == ST_ISSUE);
            if_rvalid = (r_state == ST_RESP) && (r_owner == OWN_IF);
            d_rvalid  = (r_state == ST_RESP) && (r_owner == OWN_D);
        end
    end

    // Latch the winner's request; memory fields hold between transactions
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_owner <= OWN_IF;
            r_we    <= 1'b0;
            r_be    <= 4'h0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
        end else if (w_grant_d) begin
            r_owner <= OWN_D;
            r_we    <= d_we;
            r_be    <= d_we ? d_be : BE_ALL;
            r_addr  <= d_addr;
            r_wdata <= d_wdata;
        end else if (w_grant_if) begin
            r_owner <= OWN_IF;
            r_we    <= 1'b0;
            r_be    <= BE_ALL;
            r_addr  <= if_addr;
        end
    end

    // Latency counter: loaded on ISSUE, counts down through WAIT
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_lat_cnt <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_lat_cnt <= c_MEM_LAT;
        end else if (r_state == ST_WAIT) begin
            r_lat_cnt <= r_lat_cnt - LAT_W'(1);
        end
    end

    // Capture read data into the owner's register; stores complete with zero
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_if_rdata <= 32'h0;
            r_d_rdata  <= 32'h0;
        end else if (w_capture) begin
            if (r_owner == OWN_IF) begin
                r_if_rdata <= mem_rdata;
            end else begin
                r_d_rdata  <= r_we ? 32'h0 : mem_rdata;
            end
        end
    end

    assign mem_we    = r_we;
    assign mem_be    = r_be;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;

endmodule : imem_dmem_arbiter
`default_nettype wire

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-port 32-bit synchronous memory between the RV32I core's instruction-fetch port and its load/store port.
- Sits between the core and the unified memory inside chip, and sequences one memory transaction at a time.
- Data accesses have priority; a starvation guard ensures fetch progress.
- The memory has a fixed read latency; the arbiter times and returns responses to the owning requester.

Parameters:
- MEM_LAT, 1: cycles from mem_en to valid mem_rdata (range 1..8).
- STARVE_LIMIT, 4: consecutive data grants allowed while if_req is pending before fetch is forced to win (range 1..15).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  32  fetch word address (byte address, [1:0] ignored)
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  32  fetched instruction
- d_req  in  1  load/store request; held with d_* until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_be  in  4  store byte enables
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  one-cycle completion pulse (load data or store ack)
- d_rdata  out  32  load data; 0 for store completions
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_we  out  1  memory write enable (valid with mem_en)
- mem_be  out  4  memory byte enables (4'hF for fetch and load)
- mem_addr  out  32  memory byte address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; all outputs 0; starve counter 0.
  - Any in-flight transaction is dropped and produces no rvalid.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant rule, evaluated combinationally:
    - d_req only: data wins.
    - if_req only: fetch wins.
    - Both, with starve_cnt < STARVE_LIMIT: data wins.
    - Both, with starve_cnt == STARVE_LIMIT: fetch wins.
  - The winner's gnt is high in the same cycle.
  - Its request fields are latched, the owner is recorded, and the next state is ISSUE.
  - No request: stay in IDLE, gnt low.
- ISSUE:
  - mem_en=1 for exactly one cycle, driving the latched fields.
  - Fetch drives mem_we=0 and mem_be=4'hF; loads also drive mem_be=4'hF.
  - Next state is WAIT and the latency counter is loaded with MEM_LAT.
- WAIT:
  - The counter decrements each cycle.
  - In the cycle where mem_rdata is valid (MEM_LAT cycles after ISSUE), mem_rdata is registered into the owner's rdata.
  - Next state is RESP.
- RESP:
  - The owner's rvalid=1 for one cycle.
  - The owner's rdata holds the registered value (0 for stores).
  - This is also an IDLE cycle: grant evaluation per the IDLE rules happens here, so back-to-back transactions need no bubble.
- Timing: gnt at cycle T, mem_en at T+1, rdata captured at T+1+MEM_LAT, rvalid at T+2+MEM_LAT, next gnt earliest at T+2+MEM_LAT.
- Starve counter:
  - Increments on a data grant while if_req=1, saturating at STARVE_LIMIT.
  - Clears on any fetch grant.
  - Holds when if_req=0.
- Outside the cycle they pulse, gnt and rvalid are 0.
- rdata outputs hold their last value until the next capture for the same owner.
- Requests dropped before gnt are legal and are ignored.
- mem_* outputs other than mem_en hold their last value while idle.

Decomposition:
- Shared package arb_pkg:
  - state encodings for IDLE/ISSUE/WAIT/RESP;
  - owner encoding (OWN_IF=0, OWN_D=1);
  - constant BE_ALL=4'hF.
- One sub-module, arb_starve_ctr: saturating counter with inputs d_grant, if_grant, if_pending and output force_if.

Test Plan:
- Fetch only, MEM_LAT=1:
  - Stimulus: if_req=1, if_addr=0x0000_0010 at cycle 5; memory returns 0x0000_0013.
  - Required: if_gnt at 5, mem_en at 6 with mem_addr=0x10, if_rvalid at 8 with if_rdata=0x0000_0013.
- Simultaneous requests:
  - Stimulus: if_req and d_req (load, 0x100) both at cycle 5.
  - Required: d_gnt at 5, d_rvalid at 8, if_gnt at 8, if_rvalid at 11.
- Store:
  - Stimulus: d_we=1, d_be=4'b0011, d_addr=0x204, d_wdata=0xDEAD_BEEF.
  - Required: mem_en with mem_we=1, mem_be=0011, mem_wdata=0xDEADBEEF; d_rvalid pulses 2 cycles later with d_rdata=0.
- Starvation guard, STARVE_LIMIT=4:
  - Stimulus: d_req held high continuously, with if_req high throughout.
  - Required: grant order D,D,D,D,IF,D…; the starve counter clears after the IF grant.
- MEM_LAT=3:
  - Stimulus: fetch granted at cycle 10.
  - Required: mem_en at 11, rdata sampled at 14, if_rvalid at 15.
- Reset mid-operation:
  - Stimulus: reset=0 for one cycle while in WAIT, requests still high.
  - Required: no rvalid for the aborted transaction; all outputs 0 on the next edge; fresh grant in the first cycle after reset=1.
